// File: rtl/sd_sector_server.sv
// Responder for the sd_rd/sd_wr/sd_ack/sd_buff_* sector handshake, serving
// 512-byte sectors for up to VDNUM initiators out of a byte-wide image store.
module sd_sector_server #(
    parameter int VDNUM     = 3,
    parameter int SECT_AW   = 8,
    parameter int ACK_DELAY = 4
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [32*VDNUM-1:0]    sd_lba,
    input  logic [VDNUM-1:0]       sd_rd,
    input  logic [VDNUM-1:0]       sd_wr,
    output logic [VDNUM-1:0]       sd_ack,
    output logic [8:0]             sd_buff_addr,
    output logic [7:0]             sd_buff_dout,
    input  logic [8*VDNUM-1:0]     sd_buff_din,
    output logic                   sd_buff_wr,
    output logic [SECT_AW+10:0]    mem_addr,
    output logic                   mem_rd,
    input  logic [7:0]             mem_dout,
    output logic                   mem_wr,
    output logic [7:0]             mem_din,
    output logic                   busy,
    output logic                   range_err
);
    localparam int MAW = SECT_AW + 11;

    typedef enum logic [2:0] {IDLE, ACK_WAIT, XFER, DRAIN, DONE} state_t;

    state_t             state_q;
    logic [1:0]         unit_q;
    logic [SECT_AW-1:0] lba_q;
    logic               rd_q;
    logic               oor_q;
    logic [15:0]        dly_q;
    logic [9:0]         k_q;
    logic               pipe_v_q;
    logic [8:0]         pipe_k_q;
    logic [VDNUM-1:0]   ack_q;
    logic [8:0]         buff_addr_q;
    logic               buff_wr_q;
    logic [MAW-1:0]     mem_addr_q;
    logic               mem_rd_q;
    logic               mem_wr_q;
    logic               busy_q;
    logic               range_err_q;

    logic               win_valid_s;
    logic [1:0]         win_unit_s;
    logic [31:0]        win_lba_s;
    logic               win_rd_s;
    logic               win_oor_s;
    logic [7:0]         din_sel_s;

    function automatic logic [MAW-1:0] store_addr(input logic [1:0] unit,
                                                  input logic [SECT_AW-1:0] lba,
                                                  input logic [8:0] idx);
        return {unit, lba, idx};
    endfunction

    // Fixed-priority scan: iterating downward leaves the lowest requesting unit.
    always_comb begin
        win_valid_s = 1'b0;
        win_unit_s  = 2'd0;
        win_lba_s   = 32'd0;
        win_rd_s    = 1'b0;
        for (int u = VDNUM - 1; u >= 0; u--) begin
            win_valid_s = win_valid_s | sd_rd[u] | sd_wr[u];
            win_unit_s  = (sd_rd[u] | sd_wr[u]) ? 2'(u) : win_unit_s;
            win_lba_s   = (sd_rd[u] | sd_wr[u]) ? sd_lba[32*u +: 32] : win_lba_s;
            win_rd_s    = (sd_rd[u] | sd_wr[u]) ? sd_rd[u] : win_rd_s;
        end
        win_oor_s = ((win_lba_s >> SECT_AW) != 32'd0) || ({1'b0, win_unit_s} >= 3'(VDNUM));
    end

    // Write data of the unit being served.
    always_comb begin
        din_sel_s = 8'd0;
        for (int u = 0; u < VDNUM; u++) begin
            din_sel_s = (unit_q == 2'(u)) ? sd_buff_din[8*u +: 8] : din_sel_s;
        end
    end

    // Sequencer: capture, ack delay, pipelined byte transfer, drain and release.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            unit_q      <= 2'd0;
            lba_q       <= '0;
            rd_q        <= 1'b0;
            oor_q       <= 1'b0;
            dly_q       <= 16'd0;
            k_q         <= 10'd0;
            pipe_v_q    <= 1'b0;
            pipe_k_q    <= 9'd0;
            ack_q       <= '0;
            buff_addr_q <= 9'd0;
            buff_wr_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_valid_s) begin
                        unit_q  <= win_unit_s;
                        lba_q   <= win_lba_s[SECT_AW-1:0];
                        rd_q    <= win_rd_s;
                        oor_q   <= win_oor_s;
                        busy_q  <= 1'b1;
                        dly_q   <= 16'(ACK_DELAY - 1);
                        state_q <= ACK_WAIT;
                    end
                end
                ACK_WAIT: begin
                    if (dly_q == 16'd0) begin
                        ack_q       <= VDNUM'(1'b1) << unit_q;
                        range_err_q <= oor_q;
                        k_q         <= 10'd1;
                        pipe_v_q    <= 1'b1;
                        pipe_k_q    <= 9'd0;
                        if (rd_q) begin
                            mem_rd_q   <= !oor_q;
                            mem_addr_q <= store_addr(unit_q, lba_q, 9'd0);
                        end else begin
                            buff_addr_q <= 9'd0;
                        end
                        state_q <= XFER;
                    end else begin
                        dly_q <= dly_q - 16'd1;
                    end
                end
                XFER: begin
                    // Retire the byte issued last cycle, then issue the next one.
                    if (rd_q) begin
                        buff_wr_q   <= pipe_v_q;
                        buff_addr_q <= pipe_k_q;
                    end else begin
                        mem_wr_q   <= pipe_v_q && !oor_q;
                        mem_addr_q <= store_addr(unit_q, lba_q, pipe_k_q);
                    end
                    if (k_q == 10'd512) begin
                        pipe_v_q <= 1'b0;
                        mem_rd_q <= 1'b0;
                        state_q  <= DRAIN;
                    end else begin
                        pipe_v_q <= 1'b1;
                        pipe_k_q <= k_q[8:0];
                        k_q      <= k_q + 10'd1;
                        if (rd_q) begin
                            mem_rd_q   <= !oor_q;
                            mem_addr_q <= store_addr(unit_q, lba_q, k_q[8:0]);
                        end else begin
                            buff_addr_q <= k_q[8:0];
                        end
                    end
                end
                DRAIN: begin
                    buff_wr_q <= 1'b0;
                    mem_wr_q  <= 1'b0;
                    state_q   <= DONE;
                end
                DONE: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = buff_addr_q;
    assign sd_buff_wr   = buff_wr_q;
    // Store data arrives one cycle after mem_rd, exactly when the strobe is out.
    assign sd_buff_dout = (buff_wr_q && !oor_q) ? mem_dout : 8'd0;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_wr       = mem_wr_q;
    assign mem_din      = mem_wr_q ? din_sel_s : 8'd0;
    assign busy         = busy_q;
    assign range_err    = range_err_q;

endmodule

// File: tb/tb_sd_sector_server.sv
// Randomized bench for sd_sector_server: behavioural image store, initiator
// buffers and a reference image predicting every byte and strobe count.
module tb_sd_sector_server;
    localparam int VDNUM = 3;
    localparam int SECT_AW = 8;
    localparam int ACK_DELAY = 4;
    localparam int MAW = 19;
    localparam int MEMSZ = 1 << 19;

    logic                 clk_sys = 1'b0;
    logic                 reset_n;
    logic [32*VDNUM-1:0]  sd_lba;
    logic [VDNUM-1:0]     sd_rd;
    logic [VDNUM-1:0]     sd_wr;
    logic [VDNUM-1:0]     sd_ack;
    logic [8:0]           sd_buff_addr;
    logic [7:0]           sd_buff_dout;
    logic [8*VDNUM-1:0]   sd_buff_din = '0;
    logic                 sd_buff_wr;
    logic [MAW-1:0]       mem_addr;
    logic                 mem_rd;
    logic [7:0]           mem_dout = 8'd0;
    logic                 mem_wr;
    logic [7:0]           mem_din;
    logic                 busy;
    logic                 range_err;

    logic [7:0] store   [MEMSZ];
    logic [7:0] ref_img [MEMSZ];
    logic [7:0] wbuf    [VDNUM][512];
    logic [7:0] exp_rd  [512];
    bit         mem_init = 1'b0;
    bit         inv_pat  = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int n_bwr = 0, n_mwr = 0, n_mrd = 0, n_rerr = 0, n_bad = 0;
    int n_multi = 0, n_outside = 0, n_gap = 0, bidx = 0;
    logic [VDNUM-1:0] prev_ack = '0;

    sd_sector_server #(.VDNUM(VDNUM), .SECT_AW(SECT_AW), .ACK_DELAY(ACK_DELAY)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .busy(busy), .range_err(range_err)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] init_byte(input int i);
        logic [31:0] x;
        x = 32'(i) * 32'd40503;
        if ((i >> 9) == 5) return 8'(i);
        return x[11:4] ^ 8'(i >> 9);
    endfunction

    function automatic int addr_of(input int u, input logic [31:0] lba, input int i);
        return (u << 17) | (int'(lba[7:0]) << 9) | i;
    endfunction

    function automatic logic [63:0] outs_vec();
        return 64'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd,
                    mem_wr, mem_din, busy, range_err});
    endfunction

    // Image store: synchronous read, data valid the cycle after mem_rd.
    always @(posedge clk_sys) begin
        if (!mem_init) begin
            for (int i = 0; i < MEMSZ; i++) store[i] = init_byte(i);
            mem_init = 1'b1;
        end
        if (mem_rd) mem_dout <= store[mem_addr];
        if (mem_wr) store[mem_addr] = mem_din;
    end

    // Initiator buffers: byte appears one cycle after sd_buff_addr.
    always @(posedge clk_sys) begin
        for (int u = 0; u < VDNUM; u++) sd_buff_din[8*u +: 8] <= wbuf[u][sd_buff_addr];
    end

    // Bus monitor: strobe counts, read data against prediction, ack protocol.
    always @(negedge clk_sys) begin
        if (sd_buff_wr) begin
            if (sd_buff_addr != 9'(bidx) || sd_buff_dout !== exp_rd[bidx[8:0]]) n_bad++;
            n_bwr++;
            bidx++;
        end
        if (sd_ack == '0) bidx = 0;
        if (mem_wr) n_mwr++;
        if (mem_rd) n_mrd++;
        if (range_err) n_rerr++;
        if ($countones(sd_ack) > 1) n_multi++;
        if ((sd_buff_wr || mem_wr || mem_rd) && sd_ack == '0) n_outside++;
        if (sd_ack != '0 && prev_ack != '0 && sd_ack != prev_ack) n_gap++;
        prev_ack = sd_ack;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic prep(input int u, input logic [31:0] lba, input bit is_rd, input bit oor);
        for (int i = 0; i < 512; i++) begin
            if (is_rd) exp_rd[i] = oor ? 8'd0 : ref_img[addr_of(u, lba, i)];
            else wbuf[u][i] = inv_pat ? ~8'(i) : 8'($urandom);
        end
    endtask

    task automatic post(input int u, input logic [31:0] lba, input bit is_rd, input bit oor);
        int mism;
        mism = 0;
        if (!is_rd && !oor)
            for (int i = 0; i < 512; i++) ref_img[addr_of(u, lba, i)] = wbuf[u][i];
        for (int i = 0; i < 512; i++)
            if (store[addr_of(u, lba, i)] !== ref_img[addr_of(u, lba, i)]) mism++;
        chk("sector_data", mism, 0);
    endtask

    task automatic wait_rise(output int lat);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_sys);
            lat++;
            if (sd_ack != '0) break;
        end
        if (sd_ack == '0) chk("ack_rise_timeout", 0, 1);
    endtask

    task automatic wait_fall(output int len);
        len = 1;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk_sys);
            if (sd_ack == '0) break;
            len++;
        end
    endtask

    task automatic run_xfer(input int u, input logic [31:0] lba, input bit rd, input bit wr);
        int lat, len, b_bwr, b_mwr, b_mrd, b_rerr, b_bad;
        bit oor;
        logic [VDNUM-1:0] oh;
        oor = (lba >> SECT_AW) != 32'd0;
        oh = '0;
        oh[u] = 1'b1;
        prep(u, lba, rd, oor);
        b_bwr = n_bwr; b_mwr = n_mwr; b_mrd = n_mrd; b_rerr = n_rerr; b_bad = n_bad;
        sd_lba[32*u +: 32] = lba;
        sd_rd[u] = rd;
        sd_wr[u] = wr;
        wait_rise(lat);
        chk("ack_latency", lat - 1, ACK_DELAY);
        chk("ack_onehot", sd_ack, oh);
        chk("busy_active", busy, 1);
        chk("range_err_at_rise", range_err, oor);
        sd_rd[u] = 1'b0;
        sd_wr[u] = 1'b0;
        wait_fall(len);
        chk("ack_len", len, 514);
        chk("busy_idle", busy, 0);
        chk("n_buff_wr", n_bwr - b_bwr, rd ? 512 : 0);
        chk("n_mem_rd", n_mrd - b_mrd, (rd && !oor) ? 512 : 0);
        chk("n_mem_wr", n_mwr - b_mwr, (!rd && !oor) ? 512 : 0);
        chk("read_bytes", n_bad - b_bad, 0);
        chk("range_err_cnt", n_rerr - b_rerr, oor);
        post(u, lba, rd, oor);
    endtask

    task automatic reset_mid();
        int lat, b;
        prep(0, 32'd9, 1'b1, 1'b0);
        sd_lba[31:0] = 32'd9;
        sd_rd[0] = 1'b1;
        wait_rise(lat);
        sd_rd[0] = 1'b0;
        b = n_bwr;
        for (int c = 0; c < 300 && (n_bwr - b) <= 100; c++) @(negedge clk_sys);
        chk("mid_byte100_reached", (n_bwr - b) > 100, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outs", outs_vec(), 0);
        repeat (3) @(negedge clk_sys);
        chk("mid_reset_hold", outs_vec(), 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic arbitration();
        int lat, len, b_bwr, b_mwr, b_bad;
        prep(0, 32'd17, 1'b0, 1'b0);
        prep(1, 32'd40, 1'b1, 1'b0);
        b_bwr = n_bwr; b_mwr = n_mwr; b_bad = n_bad;
        sd_lba[31:0] = 32'd17;
        sd_lba[63:32] = 32'd40;
        sd_wr[0] = 1'b1;
        sd_rd[1] = 1'b1;
        wait_rise(lat);
        chk("arb_first", sd_ack, 3'b001);
        sd_wr[0] = 1'b0;
        wait_fall(len);
        wait_rise(lat);
        chk("arb_second", sd_ack, 3'b010);
        chk("arb_second_latency", lat - 1, ACK_DELAY);
        sd_rd[1] = 1'b0;
        wait_fall(len);
        chk("arb_n_mem_wr", n_mwr - b_mwr, 512);
        chk("arb_n_buff_wr", n_bwr - b_bwr, 512);
        chk("arb_read_bytes", n_bad - b_bad, 0);
        post(0, 32'd17, 1'b0, 1'b0);
        post(1, 32'd40, 1'b1, 1'b0);
    endtask

    initial begin
        int mism, u, d;
        logic [31:0] lba;
        reset_n = 1'b0;
        sd_lba = '0;
        sd_rd = '0;
        sd_wr = '0;
        for (int i = 0; i < MEMSZ; i++) ref_img[i] = init_byte(i);
        for (int v = 0; v < VDNUM; v++)
            for (int i = 0; i < 512; i++) wbuf[v][i] = 8'd0;
        repeat (3) @(negedge clk_sys);
        chk("reset_outs", outs_vec(), 0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        run_xfer(0, 32'd5, 1'b1, 1'b0);
        inv_pat = 1'b1;
        run_xfer(2, 32'd3, 1'b0, 1'b1);
        inv_pat = 1'b0;
        run_xfer(0, 32'd256, 1'b1, 1'b0);
        run_xfer(1, 32'h8000_0002, 1'b0, 1'b1);
        run_xfer(1, 32'd7, 1'b1, 1'b1);
        arbitration();
        reset_mid();
        run_xfer(2, 32'd3, 1'b1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            u = $urandom_range(0, VDNUM - 1);
            lba = ($urandom_range(0, 4) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 255));
            d = $urandom_range(0, 2);
            run_xfer(u, lba, d != 1, d != 0);
        end

        mism = 0;
        for (int i = 0; i < MEMSZ; i++) if (store[i] !== ref_img[i]) mism++;
        chk("image_whole", mism, 0);
        chk("ack_multi_hot", n_multi, 0);
        chk("strobe_outside_ack", n_outside, 0);
        chk("ack_no_gap", n_gap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_sector_server.md
Name: sd_sector_server

Overview:
- Responder end of the sd_rd/sd_wr/sd_ack/sd_buff_* block handshake used by floppy_track and the HDD request logic.
- Serves 512-byte sector requests from up to VDNUM initiators out of a local byte-wide image store. Typical stores are a built-in ramdisk or a simulation image in BRAM.
- Same handshake timing as the HPS side: initiators raise sd_rd/sd_wr, drop it on sd_ack rise, and treat sd_ack fall as done.

Parameters:
- VDNUM, 3, number of initiator units (1..4).
- SECT_AW, 8, sector index bits per unit; each unit owns 2^SECT_AW sectors.
- ACK_DELAY, 4, clk_sys cycles from request capture to sd_ack rise (≥1).

Ports:
- clk_sys  in  1  system clock (14 MHz domain)
- reset_n  in  1  asynchronous, active-low reset
- sd_lba  in  32*VDNUM  per-unit sector number, unit u at [32u+31:32u]
- sd_rd  in  VDNUM  per-unit read request (level)
- sd_wr  in  VDNUM  per-unit write request (level)
- sd_ack  out  VDNUM  per-unit acknowledge, high for the whole transfer
- sd_buff_addr  out  9  byte index within sector
- sd_buff_dout  out  8  read data toward initiator
- sd_buff_din  in  8*VDNUM  per-unit write data from initiator buffer, valid 1 cycle after sd_buff_addr
- sd_buff_wr  out  1  strobe: sd_buff_dout valid for sd_buff_addr
- mem_addr  out  2+SECT_AW+9  image store address {unit[1:0], lba[SECT_AW-1:0], byte[8:0]}
- mem_rd  out  1  store read strobe; data valid next cycle
- mem_dout  in  8  store read data
- mem_wr  out  1  store write strobe
- mem_din  out  8  store write data
- busy  out  1  transaction in progress
- range_err  out  1  one-cycle pulse when a request had out-of-range LBA

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0: sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_*, busy, range_err. An in-flight transfer is abandoned with no further strobes.
- States: IDLE -> ACK_WAIT -> XFER -> DRAIN -> DONE -> IDLE.
- IDLE:
  - Scan units 0..VDNUM-1; lowest index with sd_rd|sd_wr wins.
  - Latch unit, lba, and dir; dir=read if sd_rd set, read has priority over a simultaneous wr.
  - Set busy=1; load delay counter with ACK_DELAY-1; go to ACK_WAIT.
- ACK_WAIT: count down. At 0, set sd_ack[unit]=1, byte counter k=0, go to XFER.
- XFER, read (store -> initiator):
  - Cycle k: mem_rd=1, mem_addr={unit,lba,k}.
  - Cycle k+1: sd_buff_wr=1, sd_buff_addr=k, sd_buff_dout=mem_dout.
  - One byte per cycle, pipelined. After k=511 is issued go to DRAIN.
- XFER, write (initiator -> store):
  - Cycle k: sd_buff_addr=k.
  - Cycle k+1: mem_wr=1, mem_addr={unit,lba,k}, mem_din=sd_buff_din[unit].
  - After k=511 is issued go to DRAIN.
- DRAIN: one cycle to complete the last pipelined strobe (byte 511).
- DONE:
  - sd_ack[unit]=0 and busy=0, then go to IDLE.
  - The next request cannot be captured before the cycle after DONE, giving ≥1 cycle of ack-low gap.
- Byte counter k is 10-bit internally, terminating at 512; sd_buff_addr is k[8:0].
- Range check:
  - An LBA is out of range if lba[31:SECT_AW]≠0 or unit ≥ VDNUM.
  - Read out of range: mem_rd held 0, sd_buff_dout=0 for all 512 strobes.
  - Write out of range: mem_wr held 0.
  - Full handshake timing is preserved either way. range_err pulses in the cycle sd_ack rises.
- Requests changing during a transfer are ignored.
- A request still asserted after DONE is served again; initiators must drop it on ack rise.
- sd_ack is exactly one-hot or zero.
- Total ack-high length: 514 cycles (512 XFER + DRAIN + DONE boundary).

Test Plan:
- Read: preload store unit0 sector 5 byte i = i[7:0]; pulse sd_rd[0] with lba=5 -> sd_ack[0] rises 4 cycles after capture. Bench sees 512 sd_buff_wr strobes, addr 0..511, dout = addr[7:0], one per cycle. Ack falls after the last strobe.
- Write: sd_wr[2], lba=3, initiator buffer byte i = ~i[7:0] -> store {2,3,i} = ~i. Exactly 512 mem_wr, no sd_buff_wr.
- Arbitration: sd_rd[1] and sd_wr[0] raised the same cycle -> unit 0 write served first, then unit 1 read. sd_ack never has two bits set; ≥1 cycle gap between acks.
- Range: sd_rd[0] with lba=256 (SECT_AW=8) -> range_err pulse, 512 strobes of 0x00, mem_rd never asserted.
- Reset mid-transfer: drop reset_n at byte 100 of a read -> all outputs 0 immediately. After release, a new request completes normally from byte 0.
- Simultaneous rd+wr on unit 1 -> treated as read: sd_buff_wr strobes occur, no mem_wr.
